reservation_station: RTL and testbench

- Receiving end of the dispatcher→RS interface: one instance per functional unit (ALU, MULT, BTU, LSU).
- Accepts an INST_RS packet when its RS_load bit is high; reports fullness back as its RS_is_full bit.
- Snoops the CDB to wake up operands waiting on ROB tags.
- Issues one fully-ready entry per cycle to its FU with a valid/ready handshake.

---
 rtl/reservation_station.sv | 217 +++++++++++++++++++++
 tb/tb_reservation_station.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: receiving end of the dispatcher-to-RS interface for one
// functional unit. Accepts dispatched instructions into the lowest free entry,
// wakes waiting operands from the CDB, and issues one fully-ready entry per
// cycle through a valid/ready handshake.
// Optional macro RS_AGE_SELECT_EN: when defined, each entry keeps a saturating
// age and the oldest ready entry issues first; otherwise the lowest-index
// ready entry issues and no ages are stored.
module reservation_station #(
    parameter int RS_SIZE     = 4,
    parameter int ROB_TAG_LEN = 3,
    parameter int XLEN        = 32,
    parameter int FUNC_LEN    = 4,
    localparam int INST_W     = FUNC_LEN + 3 * ROB_TAG_LEN + 2 + 4 * XLEN
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [INST_W-1:0]      inst_rs,
    output logic                   is_full,
    input  logic                   flush,
    input  logic                   cdb_valid,
    input  logic [ROB_TAG_LEN-1:0] cdb_tag,
    input  logic [XLEN-1:0]        cdb_value,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [FUNC_LEN-1:0]    issue_func,
    output logic [ROB_TAG_LEN-1:0] issue_tag_dest,
    output logic [XLEN-1:0]        issue_value_src1,
    output logic [XLEN-1:0]        issue_value_src2,
    output logic [XLEN-1:0]        issue_imm,
    output logic [XLEN-1:0]        issue_pc
);
    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic [FUNC_LEN-1:0]    func;
        logic [ROB_TAG_LEN-1:0] tag_dest;
        logic [ROB_TAG_LEN-1:0] tag_src1;
        logic [ROB_TAG_LEN-1:0] tag_src2;
        logic                   ready_src1;
        logic                   ready_src2;
        logic [XLEN-1:0]        value_src1;
        logic [XLEN-1:0]        value_src2;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        pc;
    } inst_rs_t;

    inst_rs_t           entry_q [RS_SIZE];
    inst_rs_t           entry_d [RS_SIZE];
    logic [RS_SIZE-1:0] valid_q;
    logic [RS_SIZE-1:0] valid_d;
`ifdef RS_AGE_SELECT_EN
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(RS_SIZE - 1);
    logic [IDX_W-1:0]   age_q [RS_SIZE];
    logic [IDX_W-1:0]   age_d [RS_SIZE];
    logic [IDX_W-1:0]   best_age_s;
`endif

    inst_rs_t           pkt_s;
    inst_rs_t           snoop_pkt_s;
    inst_rs_t           sel_entry_s;
    logic [RS_SIZE-1:0] cand_s;
    logic               sel_valid_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               dispatch_s;
    logic               free_s;

    assign pkt_s       = inst_rs;
    assign is_full     = &valid_q;
    assign dispatch_s  = load && !is_full;
    assign free_s      = sel_valid_s && issue_ready;
    assign sel_entry_s = entry_q[sel_idx_s];

    assign issue_valid      = sel_valid_s;
    assign issue_func       = sel_valid_s ? sel_entry_s.func       : {FUNC_LEN{1'b0}};
    assign issue_tag_dest   = sel_valid_s ? sel_entry_s.tag_dest   : {ROB_TAG_LEN{1'b0}};
    assign issue_value_src1 = sel_valid_s ? sel_entry_s.value_src1 : {XLEN{1'b0}};
    assign issue_value_src2 = sel_valid_s ? sel_entry_s.value_src2 : {XLEN{1'b0}};
    assign issue_imm        = sel_valid_s ? sel_entry_s.imm        : {XLEN{1'b0}};
    assign issue_pc         = sel_valid_s ? sel_entry_s.pc         : {XLEN{1'b0}};

    // Issue selection over registered state: oldest ready entry in age mode, else lowest index.
    always_comb begin
        cand_s      = '0;
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
`ifdef RS_AGE_SELECT_EN
        best_age_s  = '0;
`endif
        for (int i = 0; i < RS_SIZE; i++) begin
            cand_s[i] = valid_q[i] & entry_q[i].ready_src1 & entry_q[i].ready_src2;
`ifdef RS_AGE_SELECT_EN
            // Strict '>' keeps the lower index on equal ages.
            if (cand_s[i] && (!sel_valid_s || (age_q[i] > best_age_s))) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
                best_age_s  = age_q[i];
            end else begin
                sel_valid_s = sel_valid_s;
            end
`else
            if (cand_s[i] && !sel_valid_s) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
            end else begin
                sel_valid_s = sel_valid_s;
            end
`endif
        end
    end

    // Lowest-index free entry from the registered occupancy (a slot freed this edge is not reused).
    always_comb begin
        free_idx_s = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Apply same-cycle CDB snoop to the incoming packet so a concurrent broadcast is not missed.
    always_comb begin
        snoop_pkt_s = pkt_s;
        if (cdb_valid && !pkt_s.ready_src1 && (pkt_s.tag_src1 == cdb_tag)) begin
            snoop_pkt_s.ready_src1 = 1'b1;
            snoop_pkt_s.value_src1 = cdb_value;
        end else begin
            snoop_pkt_s.ready_src1 = pkt_s.ready_src1;
        end
        if (cdb_valid && !pkt_s.ready_src2 && (pkt_s.tag_src2 == cdb_tag)) begin
            snoop_pkt_s.ready_src2 = 1'b1;
            snoop_pkt_s.value_src2 = cdb_value;
        end else begin
            snoop_pkt_s.ready_src2 = pkt_s.ready_src2;
        end
    end

    // Next state: wakeup, issue-free and dispatch apply independently; flush overrides all.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
`ifdef RS_AGE_SELECT_EN
        age_d   = age_q;
`endif
        for (int i = 0; i < RS_SIZE; i++) begin
            if (cdb_valid && valid_q[i] && !entry_q[i].ready_src1 && (entry_q[i].tag_src1 == cdb_tag)) begin
                entry_d[i].ready_src1 = 1'b1;
                entry_d[i].value_src1 = cdb_value;
            end else begin
                entry_d[i].ready_src1 = entry_q[i].ready_src1;
            end
            if (cdb_valid && valid_q[i] && !entry_q[i].ready_src2 && (entry_q[i].tag_src2 == cdb_tag)) begin
                entry_d[i].ready_src2 = 1'b1;
                entry_d[i].value_src2 = cdb_value;
            end else begin
                entry_d[i].ready_src2 = entry_q[i].ready_src2;
            end
        end
        if (free_s) begin
            valid_d[sel_idx_s] = 1'b0;
        end else begin
            valid_d = valid_d;
        end
        if (dispatch_s) begin
`ifdef RS_AGE_SELECT_EN
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end else begin
                    age_d[i] = age_d[i];
                end
            end
            age_d[free_idx_s] = '0;
`endif
            entry_d[free_idx_s] = snoop_pkt_s;
            valid_d[free_idx_s] = 1'b1;
        end else begin
            valid_d = valid_d;
        end
        if (flush) begin
            valid_d = '0;
`ifdef RS_AGE_SELECT_EN
            for (int i = 0; i < RS_SIZE; i++) begin
                age_d[i] = '0;
            end
`endif
        end else begin
            valid_d = valid_d;
        end
    end

    // Entry state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= '0;
`ifdef RS_AGE_SELECT_EN
                age_q[i]   <= '0;
`endif
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= entry_d[i];
`ifdef RS_AGE_SELECT_EN
                age_q[i]   <= age_d[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the reservation station.
// Honours RS_AGE_SELECT_EN the same way the design does.
module tb_reservation_station;
    localparam int RS = 4;
    localparam int TL = 3;
    localparam int XL = 32;
    localparam int FL = 4;
    localparam int IW = FL + 3 * TL + 2 + 4 * XL;
    localparam int OW = FL + TL + 4 * XL;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load, flush, cdb_valid, issue_ready;
    logic [TL-1:0] cdb_tag;
    logic [XL-1:0] cdb_value;
    logic [IW-1:0] inst_rs;
    logic          is_full, issue_valid;
    logic [FL-1:0] issue_func;
    logic [TL-1:0] issue_tag_dest;
    logic [XL-1:0] issue_value_src1, issue_value_src2, issue_imm, issue_pc;

    // stimulus packet fields
    logic [FL-1:0] p_func;
    logic [TL-1:0] p_td, p_t1, p_t2;
    logic          p_r1, p_r2;
    logic [XL-1:0] p_v1, p_v2, p_imm, p_pc;
    assign inst_rs = {p_func, p_td, p_t1, p_t2, p_r1, p_r2, p_v1, p_v2, p_imm, p_pc};

    // behavioural model: slot array plus a global dispatch counter for ages
    bit            m_valid [RS];
    bit            m_r1 [RS];
    bit            m_r2 [RS];
    logic [TL-1:0] m_t1 [RS];
    logic [TL-1:0] m_t2 [RS];
    logic [TL-1:0] m_td [RS];
    logic [XL-1:0] m_v1 [RS];
    logic [XL-1:0] m_v2 [RS];
    logic [XL-1:0] m_imm [RS];
    logic [XL-1:0] m_pc [RS];
    logic [FL-1:0] m_func [RS];
    int unsigned   m_seq [RS];
    int unsigned   disp_cnt = 0;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    reservation_station #(.RS_SIZE(RS), .ROB_TAG_LEN(TL), .XLEN(XL), .FUNC_LEN(FL)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .inst_rs(inst_rs), .is_full(is_full),
        .flush(flush), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
        .issue_tag_dest(issue_tag_dest), .issue_value_src1(issue_value_src1),
        .issue_value_src2(issue_value_src2), .issue_imm(issue_imm), .issue_pc(issue_pc)
    );

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // index of the entry that must issue, or -1
    function automatic int model_sel();
        int best;
        int best_age;
        best = -1;
        best_age = -1;
        for (int i = 0; i < RS; i++) begin
            if (m_valid[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_SELECT_EN
                int age;
                age = int'(disp_cnt - m_seq[i]) - 1;
                if (age > RS - 1) age = RS - 1;
                if (age > best_age) begin
                    best = i;
                    best_age = age;
                end
`else
                if (best < 0) best = i;
`endif
            end
        end
        return best;
    endfunction

    function automatic bit model_full();
        bit f;
        f = 1'b1;
        for (int i = 0; i < RS; i++) if (!m_valid[i]) f = 1'b0;
        return f;
    endfunction

    function automatic logic [OW-1:0] model_out(input int s);
        if (s < 0) return '0;
        return {m_func[s], m_td[s], m_v1[s], m_v2[s], m_imm[s], m_pc[s]};
    endfunction

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        int  s;
        int  fi;
        bit  full;
        s = model_sel();
        full = model_full();
        fi = -1;
        for (int i = 0; i < RS; i++) if (!m_valid[i] && fi < 0) fi = i;
        if (flush) begin
            for (int i = 0; i < RS; i++) m_valid[i] = 1'b0;
            return;
        end
        if (cdb_valid) begin
            for (int i = 0; i < RS; i++) begin
                if (m_valid[i] && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1'b1; m_v1[i] = cdb_value; end
                if (m_valid[i] && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1'b1; m_v2[i] = cdb_value; end
            end
        end
        if (s >= 0 && issue_ready) m_valid[s] = 1'b0;
        if (load && !full) begin
            m_valid[fi] = 1'b1;
            m_func[fi] = p_func; m_td[fi] = p_td; m_t1[fi] = p_t1; m_t2[fi] = p_t2;
            m_imm[fi] = p_imm; m_pc[fi] = p_pc;
            m_r1[fi] = p_r1; m_v1[fi] = p_v1;
            m_r2[fi] = p_r2; m_v2[fi] = p_v2;
            if (cdb_valid && !p_r1 && p_t1 == cdb_tag) begin m_r1[fi] = 1'b1; m_v1[fi] = cdb_value; end
            if (cdb_valid && !p_r2 && p_t2 == cdb_tag) begin m_r2[fi] = 1'b1; m_v2[fi] = cdb_value; end
            m_seq[fi] = disp_cnt;
            disp_cnt++;
        end
    endtask

    // compare DUT outputs against the model on every checked cycle
    always @(negedge clk) begin
        if (chk_en) begin
            int s;
            s = model_sel();
            check("is_full", OW'(is_full), OW'(model_full()));
            check("issue_valid", OW'(issue_valid), OW'(s >= 0));
            check("issue_fields",
                  {issue_func, issue_tag_dest, issue_value_src1, issue_value_src2, issue_imm, issue_pc},
                  model_out(s));
        end
    end

    task automatic set_pkt(input logic [TL-1:0] td, input logic [TL-1:0] t1, input logic [TL-1:0] t2,
                           input logic r1, input logic r2, input logic [XL-1:0] v1, input logic [XL-1:0] v2);
        p_func = 4'h1; p_td = td; p_t1 = t1; p_t2 = t2; p_r1 = r1; p_r2 = r2;
        p_v1 = v1; p_v2 = v2; p_imm = 32'h0000_0100 + 32'(td); p_pc = 32'h0000_1000 + 32'(td);
    endtask

    task automatic cyc(input logic ld, input logic fl, input logic cv, input logic [TL-1:0] ct,
                       input logic [XL-1:0] cval, input logic rdy);
        load = ld; flush = fl; cdb_valid = cv; cdb_tag = ct; cdb_value = cval; issue_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        load = 1'b0; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_value = 32'd0; issue_ready = 1'b0;
        set_pkt(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #12;
        check("reset_is_full", OW'(is_full), OW'(0));
        check("reset_issue_valid", OW'(issue_valid), OW'(0));
        check("reset_fields", {issue_func, issue_tag_dest, issue_value_src1, issue_value_src2, issue_imm, issue_pc}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // fill with four ready ops, issue stalled
        for (int k = 1; k <= 4; k++) begin
            set_pkt(TL'(k), 3'd0, 3'd0, 1'b1, 1'b1, 32'd5, 32'd6);
            cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
            check("fill_issue_valid", OW'(issue_valid), OW'(1));
        end
        check("fill_is_full", OW'(is_full), OW'(1));
        set_pkt(3'd5, 3'd0, 3'd0, 1'b1, 1'b1, 32'd5, 32'd6);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        check("fifth_load_ignored", OW'(is_full), OW'(1));
        for (int k = 1; k <= 4; k++) begin
            check("drain_tag", OW'(issue_tag_dest), OW'(k));
            check("drain_src", OW'({issue_value_src1, issue_value_src2}), OW'({32'd5, 32'd6}));
            cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        end
        check("drained_empty", OW'(issue_valid), OW'(0));

        // full RS with concurrent issue and load: load dropped
        for (int k = 1; k <= 4; k++) begin
            set_pkt(TL'(k), 3'd0, 3'd0, 1'b1, 1'b1, 32'd5, 32'd6);
            cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        end
        set_pkt(3'd7, 3'd0, 3'd0, 1'b1, 1'b1, 32'd9, 32'd9);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        check("full_load_dropped", OW'(is_full), OW'(0));
        check("full_next_tag", OW'(issue_tag_dest), OW'(2));
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        check("refill_accepted", OW'(is_full), OW'(1));

        // flush with three valid entries plus a same-edge load
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        set_pkt(3'd6, 3'd0, 3'd0, 1'b1, 1'b1, 32'd1, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
        check("flush_issue_valid", OW'(issue_valid), OW'(0));
        check("flush_is_full", OW'(is_full), OW'(0));
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        check("flush_stays_empty", OW'(issue_valid), OW'(0));

        // CDB wakeup then backpressure
        set_pkt(3'd2, 3'd5, 3'd0, 1'b0, 1'b1, 32'd0, 32'd7);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        check("wait_not_ready", OW'(issue_valid), OW'(0));
        cyc(1'b0, 1'b0, 1'b1, 3'd5, 32'h10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("wake_valid", OW'(issue_valid), OW'(1));
            check("wake_fields", OW'({issue_tag_dest, issue_value_src1, issue_value_src2}),
                  OW'({3'd2, 32'h10, 32'd7}));
            if (k < 3) cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        check("bp_freed", OW'(issue_valid), OW'(0));

        // same-cycle snoop at dispatch
        set_pkt(3'd4, 3'd3, 3'd0, 1'b0, 1'b1, 32'd0, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 3'd3, 32'hAB, 1'b0);
        check("snoop_valid", OW'(issue_valid), OW'(1));
        check("snoop_src1", OW'(issue_value_src1), OW'(32'hAB));
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);

        // ordering: older A in slot 1, younger B in slot 0
        set_pkt(3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 32'd1, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        set_pkt(3'd3, 3'd6, 3'd0, 1'b0, 1'b1, 32'd0, 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        set_pkt(3'd5, 3'd0, 3'd0, 1'b1, 1'b1, 32'd3, 32'd3);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        check("order_b_only", OW'(issue_tag_dest), OW'(5));
        cyc(1'b0, 1'b0, 1'b1, 3'd6, 32'h33, 1'b0);
`ifdef RS_AGE_SELECT_EN
        check("order_first", OW'(issue_tag_dest), OW'(3));
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        check("order_second", OW'(issue_tag_dest), OW'(5));
`else
        check("order_first", OW'(issue_tag_dest), OW'(5));
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        check("order_second", OW'(issue_tag_dest), OW'(3));
`endif
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        check("order_empty", OW'(issue_valid), OW'(0));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            p_func = FL'($urandom_range(0, 15));
            p_td = TL'($urandom_range(0, 7));
            p_t1 = TL'($urandom_range(0, 7));
            p_t2 = TL'($urandom_range(0, 7));
            p_r1 = ($urandom_range(0, 2) == 0);
            p_r2 = ($urandom_range(0, 2) == 0);
            p_v1 = $urandom; p_v2 = $urandom; p_imm = $urandom; p_pc = $urandom;
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                TL'($urandom_range(0, 7)), $urandom, $urandom_range(0, 4) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
